mux_scanner: RTL and testbench
==============================

MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1: number of idle settle cycles after each sel change before sampling (legal 0..15).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 maps channel i to data[i]; 0 maps channel i to data[7-i].
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  scan request, sampled on the rising edge of clk.
REQ-006 The block SHALL have port mux_in  input  1  selected bit returned by the downstream 8:1 multiplexer output o0.
REQ-007 The block SHALL have port sel  output  3  channel select driven to the 8:1 multiplexer, registered.
REQ-008 The block SHALL have port busy  output  1  high while a scan is in progress, registered.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking the result valid, registered.
REQ-010 The block SHALL have port data  output  8  last completed scan result, registered.

Function
REQ-011 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-012 IDLE: start=1 at a clk edge SHALL set sel=0 and busy=1, and move to SETTLE; if SETTLE=0, it SHALL move to SAMPLE instead.
REQ-013 SETTLE: the block SHALL stay for exactly SETTLE cycles, counted by an internal 4-bit counter, then move to SAMPLE.
REQ-014 SAMPLE (one cycle): the block SHALL capture mux_in into the shadow bit for channel sel at the closing edge.
REQ-015 From SAMPLE with sel<7, the block SHALL increment sel and go to SETTLE (or stay in SAMPLE if SETTLE=0).
REQ-016 From SAMPLE with sel=7, the block SHALL go to DONE, copy the full shadow (including the channel-7 bit) into data, clear busy and set done, all at the same edge.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE with done=0.
REQ-018 Latency: done SHALL rise at the 8*(SETTLE+1)th rising edge after the edge that accepted start (16 for SETTLE=1, 8 for SETTLE=0).
REQ-019 The block SHALL accept start only in IDLE; start in SETTLE, SAMPLE or DONE SHALL be ignored, not queued.
REQ-020 With start held high continuously, a new scan SHALL begin at the edge following the DONE cycle, giving one IDLE cycle between scans.
REQ-021 data SHALL hold its previous value throughout a scan and change only at the DONE-entry edge; partial results SHALL never appear on data.
REQ-022 sel SHALL remain stable for the whole SETTLE and SAMPLE period of a channel and SHALL only wrap to 0 via a new accepted start, never by incrementing from 7.
REQ-023 In IDLE and DONE, sel SHALL hold its last value (7 after any completed scan).
REQ-024 mux_in SHALL be sampled only in SAMPLE; its value in all other states SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, sel=0, busy=0, done=0, data=8'h00, shadow=0 and settle counter=0.
REQ-026 Reset asserted mid-scan SHALL discard the partial result, with data reading 8'h00 and no done pulse.
REQ-027 The first start after rst_n deasserts SHALL be honoured at the first clk edge where rst_n=1 and start=1.

Verification
REQ-028 SETTLE=1, LSB_FIRST=1, mux model returns bit sel of 8'hA5, start pulsed once -> busy high 16 cycles, done pulse at edge 16, data=8'hA5.
REQ-029 Same pattern with LSB_FIRST=0 -> data=8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with 8'h01 -> data=8'h80.
REQ-030 SETTLE=0, pattern 8'h3C -> done at edge 8, sel steps 0..7 one per cycle, data=8'h3C.
REQ-031 start re-pulsed at edges 3, 9 and 16 of a scan -> ignored, single done, data unchanged; held high -> back-to-back scans with one IDLE cycle between them.
REQ-032 rst_n pulsed low between clk edges at edge 10 of a scan -> outputs zero asynchronously, no done, next scan yields the correct pattern.
REQ-033 The mux model's value changes during SETTLE cycles only -> data reflects SAMPLE-cycle values exclusively.

Source files
------------

// File: rtl/mux_scanner.sv
// Scans an external 8:1 mux: steps sel through channels 0..7, waits SETTLE
// cycles after each select change, samples mux_in, and publishes all 8 bits at once.
module mux_scanner #(
  parameter int unsigned SETTLE    = 1,
  parameter bit          LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time, every select change goes straight to sampling.
  localparam state_t     AFTER_SEL   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] sel_q;
  logic       busy_q, done_q;
  logic [7:0] shadow_q, data_q;
  logic [7:0] shadow_d, data_d;

  // Channel-7 bit must reach data at the same edge it is sampled.
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[sel_q] = mux_in;
    for (int i = 0; i < 8; i++)
      data_d[i] = LSB_FIRST ? shadow_d[i] : shadow_d[7-i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          sel_q   <= 3'd0;
          busy_q  <= 1'b1;
          cnt_q   <= 4'd0;
          state_q <= AFTER_SEL;
        end
        S_SETTLE: if (cnt_q == SETTLE_LAST) begin
          cnt_q   <= 4'd0;
          state_q <= S_SAMPLE;
        end else begin
          cnt_q   <= cnt_q + 4'd1;
        end
        S_SAMPLE: begin
          shadow_q <= shadow_d;
          if (sel_q == 3'd7) begin
            data_q  <= data_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sel_q   <= sel_q + 3'd1;
            state_q <= AFTER_SEL;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign data = data_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench: three scanner variants (S1/LSB, S1/MSB, S0/LSB) share start and
// reset; each sees its own modelled 8:1 mux returning bit sel of a test pattern.
module tb_mux_scanner;
  logic clk = 1'b0;
  logic rst_n, start, garble;
  logic [7:0] pat0, pat1, pat2;
  logic [2:0] sel0, sel1, sel2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [7:0] data0, data1, data2;
  logic mux0, mux1, mux2;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  assign mux0 = pat0[sel0] ^ garble;
  assign mux1 = pat1[sel1];
  assign mux2 = pat2[sel2];

  mux_scanner #(.SETTLE(1), .LSB_FIRST(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start),
    .mux_in(mux0), .sel(sel0), .busy(busy0), .done(done0), .data(data0));
  mux_scanner #(.SETTLE(1), .LSB_FIRST(0)) u1 (.clk(clk), .rst_n(rst_n), .start(start),
    .mux_in(mux1), .sel(sel1), .busy(busy1), .done(done1), .data(data1));
  mux_scanner #(.SETTLE(0), .LSB_FIRST(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start),
    .mux_in(mux2), .sel(sel2), .busy(busy2), .done(done2), .data(data2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, d2, nd, e1, e2;
    rst_n = 1'b0; start = 1'b0; garble = 1'b0;
    pat0 = 8'h00; pat1 = 8'h00; pat2 = 8'h00;
    #2;
    chk("rst_sel", {29'd0, sel0}, 0);
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_data", {24'd0, data0}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // basic scan on all three variants
    pat0 = 8'hA5; pat1 = 8'hA5; pat2 = 8'h3C;
    start = 1'b1; tick(); start = 1'b0;
    chk("acc_busy", {31'd0, busy0}, 1);
    chk("acc_sel", {29'd0, sel0}, 0);
    d0 = 0; d2 = 0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (done0 && d0 == 0) d0 = n;
      if (done2 && d2 == 0) d2 = n;
      if (n < 8) chk("s0_sel_step", {29'd0, sel2}, n);
      if (n == 8) chk("hold_data0", {24'd0, data0}, 0);
      if (n == 15) chk("busy0_e15", {31'd0, busy0}, 1);
      if (n == 16) chk("busy0_e16", {31'd0, busy0}, 0);
    end
    chk("lat_s1", d0, 16);
    chk("lat_s0", d2, 8);
    chk("data0_a5", {24'd0, data0}, 8'hA5);
    chk("data1_a5", {24'd0, data1}, 8'hA5);
    chk("data2_3c", {24'd0, data2}, 8'h3C);
    chk("sel0_hold7", {29'd0, sel0}, 7);
    chk("done0_pulse", {31'd0, done0}, 0);

    // second scan: data must hold old value mid-scan
    pat0 = 8'h5A; pat1 = 8'h01;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n == 8) chk("hold_data0_b", {24'd0, data0}, 8'hA5);
    end
    chk("data0_5a", {24'd0, data0}, 8'h5A);
    chk("data1_rev", {24'd0, data1}, 8'h80);

    // start re-pulsed while busy is ignored
    pat0 = 8'hC3;
    start = 1'b1; tick(); start = 1'b0;
    nd = 0;
    for (int n = 1; n <= 30; n++) begin
      start = (n == 3 || n == 9 || n == 16);
      tick();
      if (done0) nd++;
    end
    start = 1'b0;
    chk("ignore_done_cnt", nd, 1);
    chk("ignore_data", {24'd0, data0}, 8'hC3);
    chk("ignore_busy", {31'd0, busy0}, 0);

    // start held high: back-to-back with one idle cycle
    pat0 = 8'h3C;
    start = 1'b1; tick();
    e1 = 0; e2 = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done0) begin
        if (e1 == 0) e1 = n;
        else if (e2 == 0) e2 = n;
      end
      if (n == 17) chk("b2b_idle", {31'd0, busy0}, 0);
      if (n == 18) chk("b2b_restart", {31'd0, busy0}, 1);
    end
    start = 1'b0;
    chk("b2b_done1", e1, 16);
    chk("b2b_done2", e2, 34);
    repeat (40) tick();

    // asynchronous reset mid-scan
    pat0 = 8'hFF;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", {29'd0, sel0}, 0);
    chk("arst_busy", {31'd0, busy0}, 0);
    chk("arst_data", {24'd0, data0}, 0);
    nd = 0;
    repeat (3) begin tick(); if (done0) nd++; end
    chk("arst_nodone", nd, 0);
    pat0 = 8'h96;
    @(negedge clk); rst_n = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("post_rst_acc", {31'd0, busy0}, 1);
    repeat (16) tick();
    chk("post_rst_data", {24'd0, data0}, 8'h96);
    repeat (3) tick();

    // mux output corrupted during SETTLE only
    pat0 = 8'h6C;
    start = 1'b1; tick(); start = 1'b0;
    garble = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      garble = (n % 2 == 0) && (n < 16);
    end
    garble = 1'b0;
    chk("settle_glitch_data", {24'd0, data0}, 8'h6C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
